// File: rtl/seq_recorder_pkg.sv
// rtl/seq_recorder_pkg.sv - shared state encoding and width helpers for seq_recorder
package seq_recorder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REC   = 2'd1,
        ST_FETCH = 2'd2,
        ST_SHOW  = 2'd3
    } state_t;

    function automatic int addr_w_of(input int depth);
        return $clog2(depth);
    endfunction

    // A single-slot build still carries a 1-bit slot index so port widths stay legal.
    function automatic int slot_w_of(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/seq_slot_ram.sv
// rtl/seq_slot_ram.sv - simple dual-port slot memory, one write port, registered read port
module seq_slot_ram #(
    parameter int WIDTH = 8,
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the read register is reset; it doubles as the replay output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/seq_recorder.sv
// rtl/seq_recorder.sv - multi-slot record/replay engine; REPLAY_LOOP_EN adds looped replay via loop_en
module seq_recorder
    import seq_recorder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int SLOTS = 4,
    localparam int ADDR_W = addr_w_of(DEPTH),
    localparam int SLOT_W = slot_w_of(SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SLOT_W-1:0] slot_sel,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
`ifdef REPLAY_LOOP_EN
    input  logic              loop_en,
`endif
    output logic              rec_busy,
    output logic              play_busy,
    output logic              overflow,
    output logic              done
);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q [SLOTS];
    logic [SLOT_W-1:0]   slot_q;
    logic [SLOT_W-1:0]   sel_idx;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     len_cur;
    logic                last_word;
    logic                loop_q;
    logic                done_q, ovf_q;

    logic start_rec, start_play, wr_en, rd_en, ptr_inc, ptr_clr, done_d, ovf_d;

    assign sel_idx   = (SLOTS > 1) ? slot_sel : '0;
    assign len_cur   = len_q[slot_q];
    assign last_word = (({1'b0, ptr_q} + (ADDR_W+1)'(1)) == len_cur);

    always_comb begin
        state_d    = state_q;
        start_rec  = 1'b0;
        start_play = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        ptr_inc    = 1'b0;
        ptr_clr    = 1'b0;
        done_d     = 1'b0;
        ovf_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rec_start) begin
                    start_rec = 1'b1;
                    state_d   = ST_REC;
                end else if (play_start) begin
                    if (len_q[sel_idx] == '0) begin
                        done_d = 1'b1;
                    end else begin
                        start_play = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            ST_REC: begin
                if (in_valid) begin
                    if (len_cur == (ADDR_W+1)'(DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (out_ready) begin
                    if (!last_word) begin
                        ptr_inc = 1'b1;
                        state_d = ST_FETCH;
                    end else if (loop_q) begin
                        ptr_clr = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                len_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            if (start_rec) begin
                slot_q         <= sel_idx;
                len_q[sel_idx] <= '0;
            end
            if (wr_en) begin
                len_q[slot_q] <= len_cur + (ADDR_W+1)'(1);
            end
            if (start_play) begin
                slot_q <= sel_idx;
                ptr_q  <= '0;
            end
            if (ptr_inc) begin
                ptr_q <= ptr_q + ADDR_W'(1);
            end else if (ptr_clr) begin
                ptr_q <= '0;
            end
        end
    end

`ifdef REPLAY_LOOP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loop_q <= 1'b0;
        end else if (start_play) begin
            loop_q <= loop_en;
        end
    end
`else
    assign loop_q = 1'b0;
`endif

    seq_slot_ram #(
        .WIDTH (WIDTH),
        .WORDS (SLOTS * DEPTH),
        .AW    (SLOT_W + ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr ({slot_q, len_cur[ADDR_W-1:0]}),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr ({slot_q, ptr_q}),
        .rd_data (out_data)
    );

    assign out_valid = (state_q == ST_SHOW);
    assign rec_busy  = (state_q == ST_REC);
    assign play_busy = (state_q == ST_FETCH) || (state_q == ST_SHOW);
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_recorder.sv
// tb/tb_seq_recorder.sv - self-checking bench for seq_recorder with a queue-based slot model
module tb_seq_recorder;

    localparam int W = 8;
    localparam int D = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   slot_sel = '0;
    logic         rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic         rec_busy, play_busy, overflow, done;
    logic         loop_en = 1'b0;

    always #5 clk = ~clk;

    seq_recorder #(.WIDTH(W), .DEPTH(D), .SLOTS(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_sel   (slot_sel),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
`ifdef REPLAY_LOOP_EN
        .loop_en    (loop_en),
`endif
        .rec_busy   (rec_busy),
        .play_busy  (play_busy),
        .overflow   (overflow),
        .done       (done)
    );

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int ovf_cnt = 0;

    logic [W-1:0] mdl [S][$];
    logic [W-1:0] exp_q [$];
    bit           loop_mode = 1'b0;
    int           cur_slot = 0;

    logic         prev_valid = 1'b0, prev_ready = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] w;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("replay_word", out_data, w);
                    if (loop_mode) exp_q.push_back(w);
                end
            end
            if (out_valid && prev_valid && !prev_ready)
                chk("hold_data", out_data, prev_data);
            if (done) done_cnt <= done_cnt + 1;
            if (overflow) ovf_cnt <= ovf_cnt + 1;
        end
        prev_valid <= out_valid;
        prev_ready <= out_ready;
        prev_data  <= out_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int s = 0; s < S; s++) mdl[s].delete();
        exp_q.delete();
    endtask

    task automatic rec_begin(input int s);
        slot_sel  = 2'(s);
        rec_start = 1'b1;
        step();
        rec_start = 1'b0;
        cur_slot  = s;
        mdl[s].delete();
    endtask

    task automatic rec_word(input logic [W-1:0] d, input bit with_stop);
        in_valid = 1'b1;
        in_data  = d;
        stop     = with_stop;
        if (mdl[cur_slot].size() < D) mdl[cur_slot].push_back(d);
        step();
        in_valid = 1'b0;
        stop     = 1'b0;
    endtask

    task automatic rec_end();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic play_begin(input int s, input bit lp);
        exp_q     = mdl[s];
        loop_mode = lp;
        loop_en   = lp;
        slot_sel  = 2'(s);
        play_start = 1'b1;
        step();
        play_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            step();
            n++;
        end
        chk("done_seen", done, 1);
        chk("queue_drained", exp_q.size(), 0);
        step();
    endtask

    initial begin
        clear_model();
        rst_n = 1'b0;
        step();
        chk("reset_outputs", {out_valid, rec_busy, play_busy, overflow, done, out_data}, 0);
        step();
        rst_n = 1'b1;

        // record 41,42,43 into slot 1 and replay with literal timing
        rec_begin(1);
        chk("rec_busy_rise", rec_busy, 1);
        rec_word(8'h41, 1'b0);
        rec_word(8'h42, 1'b0);
        rec_word(8'h43, 1'b0);
        rec_end();
        chk("rec_busy_fall", rec_busy, 0);
        chk("model_len_slot1", mdl[1].size(), 3);

        out_ready = 1'b1;
        play_begin(1, 1'b0);
        chk("fetch_state", {play_busy, out_valid}, 2'b10);
        step();
        chk("w0_valid", out_valid, 1);
        chk("w0_data", out_data, 8'h41);
        step();
        chk("gap_valid", out_valid, 0);
        step();
        chk("w1_data", {out_valid, out_data}, {1'b1, 8'h42});
        step();
        step();
        chk("w2_data", {out_valid, out_data}, {1'b1, 8'h43});
        step();
        chk("last_done", {done, play_busy, out_valid}, 3'b100);
        step();
        chk("done_single", done, 0);
        chk("replay1_drained", exp_q.size(), 0);

        // backpressure for five cycles in SHOW
        out_ready = 1'b0;
        play_begin(1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h41);
            step();
        end
        out_ready = 1'b1;
        wait_done(20);

        // overflow on a DEPTH=4 slot
        begin
            int ovf0;
            ovf0 = ovf_cnt;
            rec_begin(3);
            for (int i = 0; i < 6; i++) rec_word(8'h10 + 8'(i), 1'b0);
            rec_end();
            chk("ovf_pulses", ovf_cnt - ovf0, 2);
            chk("ovf_cleared", overflow, 0);
            chk("model_len_slot3", mdl[3].size(), 4);
        end
        play_begin(3, 1'b0);
        wait_done(20);

        // empty slot gives immediate done
        play_begin(2, 1'b0);
        chk("empty_done", {done, play_busy, out_valid}, 3'b100);
        step();
        chk("empty_after", {done, out_valid}, 2'b00);

        // re-record slot 0 (last word with stop), slot 1 must be intact
        rec_begin(0);
        rec_word(8'hA0, 1'b0);
        rec_word(8'hA1, 1'b1);
        chk("stop_with_word_idle", rec_busy, 0);
        play_begin(0, 1'b0);
        wait_done(20);
        play_begin(1, 1'b0);
        wait_done(20);

        // stop mid-replay
        out_ready = 1'b0;
        play_begin(1, 1'b0);
        step();
        chk("pre_stop_valid", out_valid, 1);
        stop = 1'b1;
        exp_q.delete();
        step();
        stop = 1'b0;
        chk("stop_show", {done, out_valid, play_busy}, 3'b100);
        step();

        // reset mid-record clears every length
        rec_begin(1);
        rec_word(8'h77, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h78;
        rst_n    = 1'b0;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        clear_model();
        chk("reset_rec_idle", {rec_busy, play_busy}, 2'b00);
        play_begin(1, 1'b0);
        chk("reset_len1_zero", {done, play_busy}, 2'b10);
        step();
        play_begin(3, 1'b0);
        chk("reset_len3_zero", {done, play_busy}, 2'b10);
        step();

`ifdef REPLAY_LOOP_EN
        begin
            int d0;
            rec_begin(2);
            rec_word(8'h5A, 1'b0);
            rec_word(8'hA5, 1'b0);
            rec_end();
            out_ready = 1'b1;
            d0 = done_cnt;
            play_begin(2, 1'b1);
            for (int i = 0; i < 12; i++) step();
            chk("loop_no_done", done_cnt - d0, 0);
            chk("loop_busy", play_busy, 1);
            out_ready = 1'b0;
            stop = 1'b1;
            step();
            stop = 1'b0;
            exp_q.delete();
            loop_mode = 1'b0;
            loop_en = 1'b0;
            chk("loop_stop_done", {done, play_busy}, 2'b10);
            step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
